// File: rtl/booth_sequencer_if.sv
// Start/ready/done handshake plus datapath strobe bundle between the Booth
// sequencer (master) and the A/Q/M register datapath and host logic (slave).
interface booth_sequencer_if #(
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH + 1)
) ();

  logic             start;
  logic             ready;
  logic             done;
  logic             q0;
  logic             qm1;
  logic             load_m;
  logic             load_q;
  logic             clr_a;
  logic [1:0]       alu_op;
  logic             load_a;
  logic             shr;
  logic             dump;
  logic [CNT_W-1:0] iter;

  modport master (
    input  start, q0, qm1,
    output ready, done, load_m, load_q, clr_a, alu_op, load_a, shr, dump, iter
  );

  modport slave (
    output start, q0, qm1,
    input  ready, done, load_m, load_q, clr_a, alu_op, load_a, shr, dump, iter
  );

endinterface

// File: rtl/booth_sequencer.sv
// Moore control sequencer for a radix-2 Booth multiplier datapath.
// Optional feature macro BOOTH_ABORT_EN adds a synchronous abort input.
module booth_sequencer #(
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BOOTH_ABORT_EN
  input  logic abort,
`endif
  booth_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_ADD,
    ST_SUB,
    ST_SHIFT,
    ST_DUMP,
    ST_DONE
  } state_e;

  localparam logic [1:0]       ALU_NONE  = 2'b00;
  localparam logic [1:0]       ALU_ADD   = 2'b01;
  localparam logic [1:0]       ALU_SUB   = 2'b10;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(REG_WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] iter_inc;

  assign iter_inc = iter_q + CNT_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD: begin
        iter_d  = '0;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        // Booth recoding of the current multiplier digit pair {Q0, Q-1}.
        unique case ({bus.q0, bus.qm1})
          2'b01:   state_d = ST_ADD;
          2'b10:   state_d = ST_SUB;
          default: state_d = ST_SHIFT;
        endcase
      end
      ST_ADD:   state_d = ST_SHIFT;
      ST_SUB:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        iter_d  = iter_inc;
        state_d = (iter_inc == ITER_LAST) ? ST_DUMP : ST_EVAL;
      end
      ST_DUMP:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef BOOTH_ABORT_EN
    // Abort outranks normal sequencing anywhere outside IDLE.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      iter_d  = '0;
    end
`endif
  end

  // Strobes depend on state_q only, so the datapath sees glitch-free Moore outputs.
  always_comb begin
    bus.ready  = 1'b0;
    bus.done   = 1'b0;
    bus.load_m = 1'b0;
    bus.load_q = 1'b0;
    bus.clr_a  = 1'b0;
    bus.alu_op = ALU_NONE;
    bus.load_a = 1'b0;
    bus.shr    = 1'b0;
    bus.dump   = 1'b0;
    unique case (state_q)
      ST_IDLE:  bus.ready = 1'b1;
      ST_LOAD: begin
        bus.load_m = 1'b1;
        bus.load_q = 1'b1;
        bus.clr_a  = 1'b1;
      end
      ST_ADD: begin
        bus.alu_op = ALU_ADD;
        bus.load_a = 1'b1;
      end
      ST_SUB: begin
        bus.alu_op = ALU_SUB;
        bus.load_a = 1'b1;
      end
      ST_SHIFT: bus.shr  = 1'b1;
      ST_DUMP:  bus.dump = 1'b1;
      ST_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.iter = iter_q;

`ifndef SYNTHESIS
  a_alu_op_legal: assert property (@(posedge clk) disable iff (!rst_n)
    bus.alu_op != 2'b11);
  a_iter_range: assert property (@(posedge clk) disable iff (!rst_n)
    iter_q <= ITER_LAST);
`endif

endmodule

// File: tb/tb_booth_sequencer.sv
// Randomised self-checking bench for booth_sequencer with a behavioural
// A:Q:Q-1 datapath and a Booth-recoding reference model.
module tb_booth_sequencer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
`ifdef BOOTH_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  booth_sequencer_if #(.REG_WIDTH(N)) bus ();

  booth_sequencer #(.REG_WIDTH(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BOOTH_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural datapath driven by the sequencer strobes
  logic [N-1:0] m_val = '0;
  logic [N-1:0] q_val = '0;
  logic [N-1:0] dp_a  = '0;
  logic [N-1:0] dp_q  = '0;
  logic [N-1:0] dp_m  = '0;
  logic         dp_qm1 = 1'b0;

  assign bus.q0  = dp_q[0];
  assign bus.qm1 = dp_qm1;

  always @(posedge clk) begin
    if (bus.load_m) dp_m <= m_val;
    if (bus.load_q) dp_q <= q_val;
    if (bus.clr_a) begin
      dp_a   <= '0;
      dp_qm1 <= 1'b0;
    end
    if (bus.load_a) dp_a <= (bus.alu_op == 2'b01) ? dp_a + dp_m : dp_a - dp_m;
    if (bus.shr) {dp_a, dp_q, dp_qm1} <= {dp_a[N-1], dp_a, dp_q};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int groups_active();
    return int'(bus.ready) + int'(bus.load_m | bus.load_q | bus.clr_a)
         + int'(bus.load_a | (bus.alu_op != 2'b00)) + int'(bus.shr)
         + int'(bus.dump) + int'(bus.done);
  endfunction

  function automatic logic any_strobe();
    return bus.load_m | bus.load_q | bus.clr_a | bus.load_a | (bus.alu_op != 2'b00)
         | bus.shr | bus.dump | bus.done;
  endfunction

  // Reference: Booth digit per multiplier bit pair, cycle count, signed product
  function automatic void ref_model(input logic [N-1:0] m, input logic [N-1:0] q,
                                    output logic [2*N-1:0] ops, output int k,
                                    output logic [2*N-1:0] prod);
    logic prev;
    int   p;
    prev = 1'b0;
    ops  = '0;
    k    = 0;
    for (int i = 0; i < N; i++) begin
      if (q[i] && !prev) begin
        ops[2*i +: 2] = 2'b10;
        k++;
      end else if (!q[i] && prev) begin
        ops[2*i +: 2] = 2'b01;
        k++;
      end
      prev = q[i];
    end
    p    = int'($signed(m)) * int'($signed(q));
    prod = p[2*N-1:0];
  endfunction

  task automatic launch();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("launch_ready", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
  endtask

  // Observes one operation whose start-sampling edge is the next posedge.
  task automatic monitor_op(input logic [N-1:0] m, input logic [N-1:0] q,
                            input bit hold, input string tag);
    logic [2*N-1:0] exp_ops, seen_ops, exp_prod, prod;
    logic [1:0]     cur;
    logic [CW-1:0]  iter_end;
    int k, load_c, dump_c, done_c, ready_c, shr_n, dump_n, done_n, overlap;
    m_val = m;
    q_val = q;
    ref_model(m, q, exp_ops, k, exp_prod);
    seen_ops = '0;
    prod     = '0;
    cur      = 2'b00;
    iter_end = '0;
    load_c = -1; dump_c = -1; done_c = -1; ready_c = -1;
    shr_n = 0; dump_n = 0; done_n = 0; overlap = 0;
    @(posedge clk);
    for (int c = 1; c <= 40 && ready_c < 0; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.start = 1'b0;
      if (groups_active() > 1) overlap++;
      if (bus.load_m && bus.load_q && bus.clr_a && load_c < 0) load_c = c;
      if (bus.load_a && bus.alu_op != 2'b00) cur = bus.alu_op;
      if (bus.shr) begin
        if (shr_n < N) seen_ops[2*shr_n +: 2] = cur;
        shr_n++;
        cur = 2'b00;
      end
      if (bus.dump) begin
        dump_n++;
        dump_c = c;
        prod   = {dp_a, dp_q};
      end
      if (bus.done) begin
        done_n++;
        done_c = c;
      end
      if (bus.ready) begin
        ready_c  = c;
        iter_end = bus.iter;
      end
    end
    check({tag, "_load_cycle"}, load_c, 1);
    check({tag, "_shr_count"}, shr_n, N);
    check({tag, "_alu_ops"}, 32'(seen_ops), 32'(exp_ops));
    check({tag, "_dump_cycle"}, dump_c, 2 + 2*N + k);
    check({tag, "_done_cycle"}, done_c, 3 + 2*N + k);
    check({tag, "_ready_cycle"}, ready_c, 4 + 2*N + k);
    check({tag, "_dump_count"}, dump_n, 1);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_exclusive"}, overlap, 0);
    check({tag, "_product"}, 32'(prod), 32'(exp_prod));
    check({tag, "_iter_idle"}, 32'(iter_end), N);
  endtask

  task automatic reset_during_sub();
    int  shr_n, late;
    bit  found;
    shr_n = 0;
    late  = 0;
    found = 1'b0;
    m_val = 8'hF9;
    q_val = 8'h04;
    @(posedge clk);
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.load_a && bus.alu_op == 2'b10 && shr_n == 2) found = 1'b1;
      if (bus.shr) shr_n++;
    end
    check("rst_sub_reached", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'(any_strobe()), 32'd0);
    check("rst_mid_ready", 32'(bus.ready), 32'd1);
    check("rst_mid_iter", 32'(bus.iter), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.dump || bus.done) late++;
    end
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.dump || bus.done) late++;
    end
    check("rst_mid_no_dump_done", late, 0);
  endtask

`ifdef BOOTH_ABORT_EN
  task automatic abort_in_shift();
    int  shr_n, late;
    bit  hit;
    shr_n = 0;
    late  = 0;
    hit   = 1'b0;
    m_val = 8'h13;
    q_val = 8'h0F;
    @(posedge clk);
    for (int c = 1; c <= 40 && !hit; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.shr) begin
        shr_n++;
        if (shr_n == 4) begin
          hit   = 1'b1;
          abort = 1'b1;
        end
      end
    end
    check("abort_reached", 32'(hit), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_iter", 32'(bus.iter), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (bus.dump || bus.done) late++;
    end
    check("abort_no_dump_done", late, 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle_hits;
    bus.start = 1'b0;

    // Reset mid-clock, before any rising edge
    #3 rst_n = 1'b0;
    #1;
    check("reset_strobes", 32'(any_strobe()), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_iter", 32'(bus.iter), 32'd0);
    #18 rst_n = 1'b1;
    idle_hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (any_strobe() || !bus.ready) idle_hits++;
    end
    check("idle_quiet", idle_hits, 0);

    launch();
    monitor_op(8'h05, 8'h00, 1'b0, "zero");
    launch();
    monitor_op(8'h03, 8'hFE, 1'b0, "mixed");
    launch();
    monitor_op(8'h7F, 8'h55, 1'b0, "worst");

    // Start held high: second op launches on the first IDLE edge
    launch();
    monitor_op(8'($urandom), 8'($urandom), 1'b1, "held1");
    monitor_op(8'($urandom), 8'($urandom), 1'b0, "held2");

    launch();
    reset_during_sub();
    launch();
    monitor_op(8'hF9, 8'h04, 1'b0, "after_rst");

`ifdef BOOTH_ABORT_EN
    launch();
    abort_in_shift();
    launch();
    monitor_op(8'h13, 8'h0F, 1'b0, "after_abort");
`endif

    for (int i = 0; i < 6; i++) begin
      launch();
      monitor_op(8'($urandom), 8'($urandom), 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
